// File: rtl/uart_irq_status.sv
// UART interrupt status block: sticky W1C pending flags, enable mask, registered irq and irq_id.
// Optional IRQ_HOLDOFF_EN: holds irq low for HOLDOFF cycles after every falling edge.
module uart_irq_status #(
  parameter int            N         = 7,
  parameter logic [N-1:0]  EDGE_MASK = 7'b0001111,
  parameter logic [N-1:0]  EN_RESET  = 7'b0000000,
  parameter int            HOLDOFF   = 4,
  localparam int           IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  status_in,
  input  logic          en_we,
  input  logic [N-1:0]  en_wdata,
  input  logic          clr_we,
  input  logic [N-1:0]  clr_wdata,
  output logic [N-1:0]  enable,
  output logic [N-1:0]  pending,
  output logic          irq,
  output logic [IW-1:0] irq_id
);

  logic [N-1:0]  status_q;
  logic [N-1:0]  prev_q;
  logic [N-1:0]  set_evt;
  logic [N-1:0]  clr_mask;
  logic [N-1:0]  active;
  logic          any_active;
  logic [IW-1:0] id_next;

  // Edge sources fire only on a sampled 0->1; level sources fire every cycle they are high.
  assign set_evt    = (status_q & ~prev_q & EDGE_MASK) | (status_q & ~EDGE_MASK);
  assign clr_mask   = clr_we ? clr_wdata : '0;
  assign active     = pending & enable;
  assign any_active = |active;

  always_comb begin
    id_next = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) id_next = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q <= '0;
      prev_q   <= '0;
      pending  <= '0;
      enable   <= EN_RESET;
    end else begin
      status_q <= status_in;
      prev_q   <= status_q;
      pending  <= (pending & ~clr_mask) | set_evt;
      if (en_we) enable <= en_wdata;
    end
  end

`ifdef IRQ_HOLDOFF_EN
  localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_next;

  // Irq is gated on the post-edge count so it stays low for exactly HOLDOFF cycles.
  always_comb begin
    hold_next = hold_cnt;
    if (irq && !any_active) hold_next = CW'(HOLDOFF);
    else if (hold_cnt != '0) hold_next = hold_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      irq      <= 1'b0;
      irq_id   <= '0;
    end else begin
      hold_cnt <= hold_next;
      irq      <= any_active && (hold_next == '0);
      irq_id   <= id_next;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      irq    <= any_active;
      irq_id <= id_next;
    end
  end
`endif

endmodule

// File: tb/tb_uart_irq_status.sv
// Self-checking bench for uart_irq_status: directed scenarios then random traffic vs a rule-level model.
// Honours IRQ_HOLDOFF_EN in both the model and the holdoff scenario.
module tb_uart_irq_status;

  localparam int           N         = 7;
  localparam int           IW        = 3;
  localparam int           HOLDOFF   = 4;
  localparam logic [N-1:0] EDGE_MASK = 7'b0001111;
  localparam logic [N-1:0] EN_RESET  = 7'b0000000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  status_in = '0;
  logic          en_we = 1'b0;
  logic [N-1:0]  en_wdata = '0;
  logic          clr_we = 1'b0;
  logic [N-1:0]  clr_wdata = '0;
  logic [N-1:0]  enable;
  logic [N-1:0]  pending;
  logic          irq;
  logic [IW-1:0] irq_id;

  uart_irq_status #(
    .N(N), .EDGE_MASK(EDGE_MASK), .EN_RESET(EN_RESET), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .reset(reset), .status_in(status_in),
    .en_we(en_we), .en_wdata(en_wdata), .clr_we(clr_we), .clr_wdata(clr_wdata),
    .enable(enable), .pending(pending), .irq(irq), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sampled history of each flag plus the rule-level outputs.
  bit [N-1:0] m_now, m_before, m_pend, m_en;
  bit         m_irq;
  int         m_id;
  int         low_run;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_now = '0; m_before = '0; m_pend = '0; m_en = EN_RESET;
    m_irq = 0; m_id = 0; low_run = HOLDOFF;
  endtask

  task automatic modelEdge();
    bit [N-1:0] next_pend;
    int first;
    bit fired, irq_new;
    first = -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i] && first < 0) first = i;
    for (int i = 0; i < N; i++) begin
      fired = EDGE_MASK[i] ? (m_now[i] && !m_before[i]) : m_now[i];
      next_pend[i] = fired || (m_pend[i] && !(clr_we && clr_wdata[i]));
    end
`ifdef IRQ_HOLDOFF_EN
    irq_new = (first >= 0) && (low_run >= HOLDOFF);
`else
    irq_new = (first >= 0);
`endif
    low_run  = irq_new ? 0 : ((low_run < 1000) ? low_run + 1 : low_run);
    m_irq    = irq_new;
    m_id     = (first >= 0) ? first : 0;
    m_en     = en_we ? en_wdata : m_en;
    m_pend   = next_pend;
    m_before = m_now;
    m_now    = status_in;
  endtask

  task automatic applyStimulus(input logic [N-1:0] st, input logic ew, input logic [N-1:0] ed,
                               input logic cw, input logic [N-1:0] cd);
    status_in = st; en_we = ew; en_wdata = ed; clr_we = cw; clr_wdata = cd;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("pending", 32'(pending), 32'(m_pend));
    checkOutput("enable",  32'(enable),  32'(m_en));
    checkOutput("irq",     32'(irq),     32'(m_irq));
    checkOutput("irq_id",  32'(irq_id),  32'(m_id));
  endtask

  initial begin
    int lows;

    // Reset held with every flag high: nothing may latch.
    status_in = 7'h7F;
    #1 reset = 1'b1;
    modelReset();
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_irq",     32'(irq),     32'h0);
    checkOutput("rst_irq_id",  32'(irq_id),  32'h0);
    checkOutput("rst_enable",  32'(enable),  32'(EN_RESET));
    reset = 1'b0;
    applyStimulus(7'h7F, 0, 0, 0, 0);
    applyStimulus(7'h7F, 0, 0, 0, 0);
    checkOutput("lvl_after_rst", 32'(pending[6:4]), 32'h7);
    repeat (3) applyStimulus(7'h00, 0, 0, 1, 7'h7F);
    checkOutput("all_cleared", 32'(pending), 32'h0);

    // fe edge pulse, enable = 01
    applyStimulus(7'h00, 1, 7'h01, 0, 0);
    applyStimulus(7'h01, 0, 0, 0, 0);
    applyStimulus(7'h00, 0, 0, 0, 0);
    checkOutput("fe_pend_k1", 32'(pending[0]), 32'h1);
    checkOutput("fe_irq_k1",  32'(irq), 32'h0);
    applyStimulus(7'h00, 0, 0, 0, 0);
    checkOutput("fe_irq_k2",  32'(irq), 32'h1);
    checkOutput("fe_id",      32'(irq_id), 32'h0);
    applyStimulus(7'h00, 0, 0, 1, 7'h01);
    applyStimulus(7'h00, 0, 0, 0, 0);
    checkOutput("fe_clr_irq", 32'(irq), 32'h0);

    // dr level source: W1C ineffective while held
    applyStimulus(7'h00, 1, 7'h40, 0, 0);
    repeat (3) applyStimulus(7'h40, 0, 0, 0, 0);
    checkOutput("dr_irq", 32'(irq), 32'h1);
    applyStimulus(7'h40, 0, 0, 1, 7'h40);
    applyStimulus(7'h40, 0, 0, 0, 0);
    checkOutput("dr_held_pend", 32'(pending[6]), 32'h1);
    checkOutput("dr_held_irq",  32'(irq), 32'h1);
    applyStimulus(7'h00, 0, 0, 0, 0);
    applyStimulus(7'h00, 0, 0, 1, 7'h40);
    applyStimulus(7'h00, 0, 0, 0, 0);
    checkOutput("dr_drop_irq",  32'(irq), 32'h0);

    // fe + dr pending: priority then handover without a low cycle
    applyStimulus(7'h00, 1, 7'h41, 0, 0);
    applyStimulus(7'h41, 0, 0, 0, 0);
    applyStimulus(7'h40, 0, 0, 0, 0);
    applyStimulus(7'h40, 0, 0, 0, 0);
    checkOutput("prio_irq", 32'(irq), 32'h1);
    checkOutput("prio_id0", 32'(irq_id), 32'h0);
    applyStimulus(7'h00, 0, 0, 0, 0);
    applyStimulus(7'h00, 0, 0, 1, 7'h01);
    checkOutput("handover_irq_m", 32'(irq), 32'h1);
    applyStimulus(7'h00, 0, 0, 0, 0);
    checkOutput("handover_irq", 32'(irq), 32'h1);
    checkOutput("handover_id6", 32'(irq_id), 32'h6);
    applyStimulus(7'h00, 0, 0, 1, 7'h40);
    applyStimulus(7'h00, 0, 0, 0, 0);

    // ore pending while disabled, then enabled
    applyStimulus(7'h00, 1, 7'h00, 0, 0);
    applyStimulus(7'h04, 0, 0, 0, 0);
    applyStimulus(7'h00, 0, 0, 0, 0);
    applyStimulus(7'h00, 0, 0, 0, 0);
    checkOutput("ore_pend", 32'(pending), 32'h04);
    checkOutput("ore_irq0", 32'(irq), 32'h0);
    applyStimulus(7'h00, 1, 7'h04, 0, 0);
    applyStimulus(7'h00, 0, 0, 0, 0);
    checkOutput("ore_irq1", 32'(irq), 32'h1);
    checkOutput("ore_id2",  32'(irq_id), 32'h2);
    applyStimulus(7'h00, 0, 0, 1, 7'h04);
    applyStimulus(7'h00, 0, 0, 0, 0);

    // Set and clear of fe in the same cycle: set wins
    applyStimulus(7'h00, 1, 7'h01, 0, 0);
    applyStimulus(7'h01, 0, 0, 0, 0);
    applyStimulus(7'h00, 0, 0, 0, 0);
    applyStimulus(7'h01, 0, 0, 0, 0);
    applyStimulus(7'h00, 0, 0, 1, 7'h01);
    checkOutput("set_wins", 32'(pending[0]), 32'h1);
    checkOutput("set_wins_irq", 32'(irq), 32'h1);

    // Clear and retrigger immediately: measure the irq-low gap
    applyStimulus(7'h01, 0, 0, 1, 7'h01);
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(7'h00, 0, 0, 0, 0);
      if (irq === 1'b0) lows++;
      else break;
    end
`ifdef IRQ_HOLDOFF_EN
    checkOutput("holdoff_lows", 32'(lows), 32'(HOLDOFF));
`else
    checkOutput("retrigger_lows", 32'(lows), 32'h1);
`endif
    applyStimulus(7'h00, 0, 0, 1, 7'h7F);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      applyStimulus(N'($urandom), ($urandom_range(0, 7) == 0), N'($urandom),
                    ($urandom_range(0, 3) == 0), N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
